// File: rtl/regfile_4mb.sv
`default_nettype none
// ============================================================================
// regfile_4mb : SPI-mapped register file (version, scratch, control, status,
//               W1C events with interrupt, write and error counters)
// Revision    : 1.0
// ============================================================================
module regfile_4mb #(
    parameter logic [31:0] FPGA_VERSION = 32'h0001_0000,
    parameter logic [31:0] UNMAPPED_VAL = 32'hDEAD_BEEF
) (
    input  logic        clk_100m,
    input  logic        rst_n_syn,
    input  logic [15:0] addr,
    input  logic [31:0] data_mosi,
    input  logic        data_mosi_rdy,
    input  logic        data_miso_rdy,
    output logic [31:0] data_miso,
    input  logic [15:0] status_in,
    input  logic [7:0]  event_in,
    output logic [23:0] ctrl_out,
    output logic        ctrl_wr,
    output logic        irq
);

    localparam logic [15:0] ADDR_VERSION  = 16'h0000;
    localparam logic [15:0] ADDR_SCRATCH  = 16'h0001;
    localparam logic [15:0] ADDR_CTRL     = 16'h0002;
    localparam logic [15:0] ADDR_STATUS   = 16'h0003;
    localparam logic [15:0] ADDR_EVENT    = 16'h0004;
    localparam logic [15:0] ADDR_WR_CNT   = 16'h0005;
    localparam logic [15:0] ADDR_ERR_CNT  = 16'h0006;
    localparam logic [15:0] ADDR_FIRST_UM = 16'h0007;
    localparam logic [15:0] CNT_MAX       = 16'hFFFF;
    localparam logic [1:0]  ARM_DONE      = 2'd2;

    logic [31:0] scratch;
    logic [31:0] ctrl;
    logic [7:0]  event_flags;
    logic [15:0] wr_cnt;
    logic [15:0] err_cnt;

    logic [15:0] status_meta;
    logic [15:0] status_sync;
    logic [7:0]  event_meta;
    logic [7:0]  event_sync;
    logic [7:0]  event_prev;
    logic [1:0]  arm_cnt;

    logic        addr_unmapped;
    logic        hit_scratch;
    logic        hit_ctrl;
    logic        hit_event;
    logic        hit_err_cnt;
    logic        wr_counted;
    logic        event_armed;
    logic [7:0]  event_rise;
    logic [7:0]  event_clr;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    logic [15:0] err_next;
    logic [15:0] wr_next;
    logic [31:0] read_val;

    // ------------------------------------------------------------------
    // Input synchronizers and event edge detector
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            status_meta <= '0;
            status_sync <= '0;
            event_meta  <= '0;
            event_sync  <= '0;
            event_prev  <= '0;
            arm_cnt     <= '0;
        end else begin
            status_meta <= status_in;
            status_sync <= status_meta;
            event_meta  <= event_in;
            event_sync  <= event_meta;
            // While arming, preload the edge reference from the first
            // stage so levels present at reset release never look like edges.
            event_prev  <= event_armed ? event_sync : event_meta;
            if (arm_cnt != ARM_DONE) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write decode and next-state terms
    // ------------------------------------------------------------------
    always_comb begin
        addr_unmapped = (addr >= ADDR_FIRST_UM);
        hit_scratch   = data_mosi_rdy && (addr == ADDR_SCRATCH);
        hit_ctrl      = data_mosi_rdy && (addr == ADDR_CTRL);
        hit_event     = data_mosi_rdy && (addr == ADDR_EVENT);
        hit_err_cnt   = data_mosi_rdy && (addr == ADDR_ERR_CNT);
        wr_counted    = hit_scratch || hit_ctrl || hit_event || hit_err_cnt;

        event_armed   = (arm_cnt == ARM_DONE);
        event_rise    = event_armed ? (event_sync & ~event_prev) : 8'h00;
        event_clr     = hit_event ? data_mosi[7:0] : 8'h00;

        // Read and write strobes at an unmapped address count separately
        err_inc  = {1'b0, data_mosi_rdy & addr_unmapped}
                 + {1'b0, data_miso_rdy & addr_unmapped};
        err_sum  = {1'b0, err_cnt} + {15'h0000, err_inc};
        err_next = err_sum[16] ? CNT_MAX : err_sum[15:0];
        wr_next  = (wr_cnt == CNT_MAX) ? CNT_MAX : (wr_cnt + 16'd1);
    end

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            scratch     <= '0;
            ctrl        <= '0;
            event_flags <= '0;
            wr_cnt      <= '0;
            err_cnt     <= '0;
            ctrl_wr     <= 1'b0;
        end else begin
            if (hit_scratch) begin
                scratch <= data_mosi;
            end
            if (hit_ctrl) begin
                ctrl <= data_mosi;
            end
            ctrl_wr <= hit_ctrl;

            // Clear first, then set: a coincident edge keeps the bit
            event_flags <= (event_flags & ~event_clr) | event_rise;

            if (wr_counted) begin
                wr_cnt <= wr_next;
            end

            if (hit_err_cnt) begin
                err_cnt <= '0;
            end else begin
                err_cnt <= err_next;
            end
        end
    end

    assign ctrl_out = ctrl[23:0];

    // ------------------------------------------------------------------
    // Read mux (registered, side-effect free)
    // ------------------------------------------------------------------
    always_comb begin
        read_val = UNMAPPED_VAL;
        case (addr)
            ADDR_VERSION: read_val = FPGA_VERSION;
            ADDR_SCRATCH: read_val = scratch;
            ADDR_CTRL:    read_val = ctrl;
            ADDR_STATUS:  read_val = {16'h0000, status_sync};
            ADDR_EVENT:   read_val = {24'h00_0000, event_flags};
            ADDR_WR_CNT:  read_val = {16'h0000, wr_cnt};
            ADDR_ERR_CNT: read_val = {16'h0000, err_cnt};
            default:      read_val = UNMAPPED_VAL;
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            data_miso <= '0;
            irq       <= 1'b0;
        end else begin
            data_miso <= read_val;
            irq       <= |(event_flags & ctrl[31:24]);
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_4mb.md
REGFILE_4MB -- requirements
Module: regfile_4mb

Interface
REQ-001 SHALL have parameter FPGA_VERSION, default 32'h0001_0000, constant returned by VERSION register.
REQ-002 SHALL have parameter UNMAPPED_VAL, default 32'hDEAD_BEEF, read value for unmapped addresses.
REQ-003 SHALL have port clk_100m  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_syn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addr  input  16  register address from SPI slave.
REQ-006 SHALL have port data_mosi  input  32  write data from SPI slave.
REQ-007 SHALL have port data_mosi_rdy  input  1  one-cycle write commit pulse.
REQ-008 SHALL have port data_miso_rdy  input  1  one-cycle read-complete pulse.
REQ-009 SHALL have port data_miso  output  32  read data to SPI slave.
REQ-010 SHALL have port status_in  input  16  asynchronous status levels.
REQ-011 SHALL have port event_in  input  8  asynchronous event levels.
REQ-012 SHALL have port ctrl_out  output  24  CTRL[23:0].
REQ-013 SHALL have port ctrl_wr  output  1  one-cycle pulse on each CTRL write.
REQ-014 SHALL have port irq  output  1  registered interrupt request, active high.

Function
REQ-015 SHALL implement map: 0x0000 VERSION RO; 0x0001 SCRATCH RW; 0x0002 CTRL RW; 0x0003 STATUS RO {16'h0, status_sync}; 0x0004 EVENT W1C {24'h0, event[7:0]}; 0x0005 WR_CNT RO {16'h0, cnt}; 0x0006 ERR_CNT {16'h0, cnt}, any write clears.
REQ-016 SHALL synchronize status_in and event_in through two flops each before use.
REQ-017 SHALL commit a write on the cycle data_mosi_rdy=1; new value visible on outputs the next cycle.
REQ-018 SHALL ignore writes to VERSION, STATUS, WR_CNT (no state change, not an error).
REQ-019 SHALL register data_miso every cycle from current addr: one-cycle latency addr -> data_miso, no read side effects.
REQ-020 SHALL drive data_miso=UNMAPPED_VAL for addr >= 0x0007.
REQ-021 SHALL set EVENT[i] on a rising edge (0->1) of synchronized event_in[i]; bit stays set until cleared.
REQ-022 SHALL clear EVENT[i] when writing 1 to bit i at 0x0004; writing 0 has no effect.
REQ-023 SHALL let set win over clear when rising edge and W1C hit the same bit in the same cycle.
REQ-024 SHALL increment WR_CNT by 1 per committed write to a mapped RW/W1C/ERR_CNT address; saturate at 16'hFFFF.
REQ-025 SHALL increment ERR_CNT by 1 per data_mosi_rdy or data_miso_rdy pulse with unmapped addr; saturate at 16'hFFFF.
REQ-026 SHALL clear ERR_CNT on any write to 0x0006; clear takes effect even if an increment would apply the same cycle.
REQ-027 SHALL pulse ctrl_wr for exactly one cycle, aligned with ctrl_out update, per write to 0x0002 (including same-value writes).
REQ-028 SHALL compute irq = |(EVENT & CTRL[31:24]), registered (one cycle after EVENT/CTRL change).
REQ-029 SHALL treat data_mosi_rdy and data_miso_rdy in the same cycle as two independent events (both counted if unmapped).

Reset
REQ-030 SHALL, on rst_n_syn=0, immediately set SCRATCH, CTRL, EVENT, WR_CNT, ERR_CNT, sync flops to 0; data_miso=0; ctrl_out=0; ctrl_wr=0; irq=0.
REQ-031 SHALL abort any in-progress update on reset assertion; first valid commit is the first data_mosi_rdy after release.
REQ-032 SHALL not latch events from sync flops during the two cycles after reset release (edge detector seeded with synchronized value).

Verification
REQ-033 Reset, addr=0x0000 -> data_miso=32'h0001_0000 one cycle later; all other outputs 0.
REQ-034 Write 0xA5A5_1234 to 0x0002 -> ctrl_out=24'hA5_1234, ctrl_wr high one cycle, WR_CNT=1.
REQ-035 event_in[3] 0->1 with CTRL[27]=1 -> EVENT=0x08, irq=1; write 0x08 to 0x0004 with event_in held high -> EVENT=0, irq=0 next cycle.
REQ-036 Rising edge on event_in[0] coinciding with W1C 0x01 -> EVENT[0] remains 1.
REQ-037 data_miso_rdy at addr 0x0100 -> data_miso=32'hDEAD_BEEF, ERR_CNT=1; 65536 further pulses -> ERR_CNT=0xFFFF; write 0x0006 -> 0.
REQ-038 Assert rst_n_syn mid-sequence after SCRATCH=0x1 -> SCRATCH=0, WR_CNT=0 without waiting for a clock edge.
